// File: rtl/ext_lights_pkg.sv
// Shared smart-home lighting definitions: luminosity width, default thresholds
// and the lamp state type used by the exterior-lighting controller.
package ext_lights_pkg;

    localparam int LUM_W          = 8;
    localparam int CNT_W          = 8;
    localparam int DEF_ON_THRESH  = 50;
    localparam int DEF_OFF_THRESH = 50;

    typedef enum logic {
        LIGHT_OFF = 1'b0,
        LIGHT_ON  = 1'b1
    } lamp_state_t;

endpackage

// File: rtl/ext_lights_debounce.sv
// Threshold compare with hysteresis and a saturating stability counter; raises
// a one-cycle toggle strobe when enough consecutive samples favour the other state.
module lum_debounce
    import ext_lights_pkg::*;
#(
    parameter int ON_THRESH     = DEF_ON_THRESH,
    parameter int OFF_THRESH    = DEF_OFF_THRESH,
    parameter int STABLE_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [LUM_W-1:0] i_lum,
    input  lamp_state_t      i_state,
    output logic             o_toggle
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic             w_dark;
    logic             w_bright;
    logic             w_qual;
    logic             w_done;
    logic [CNT_W-1:0] r_cnt;

    assign w_dark   = (int'(i_lum) < ON_THRESH);
    assign w_bright = (int'(i_lum) >= OFF_THRESH);
    // A sample only counts if it argues for leaving the current state.
    assign w_qual   = (i_state == LIGHT_ON) ? w_bright : w_dark;
    assign w_done   = w_qual && (int'(r_cnt) >= STABLE_CYCLES - 1);
    assign o_toggle = w_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!w_qual || w_done) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/ext_lights.sv
// Exterior-lighting controller: holds the registered lamp state and flips it
// whenever the debounce stage reports a stable change of ambient light.
module ext_lights
    import ext_lights_pkg::*;
#(
    parameter int ON_THRESH     = DEF_ON_THRESH,
    parameter int OFF_THRESH    = DEF_OFF_THRESH,
    parameter int STABLE_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [LUM_W-1:0] Lum_sen,
    output logic             Ext_light
);

    lamp_state_t r_state;
    logic        w_toggle;

    if ((OFF_THRESH < ON_THRESH) || (STABLE_CYCLES == 0)) begin : g_cfg_err
        $error("ext_lights: need OFF_THRESH >= ON_THRESH and STABLE_CYCLES >= 1");
    end

    lum_debounce #(
        .ON_THRESH    (ON_THRESH),
        .OFF_THRESH   (OFF_THRESH),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debounce (
        .i_clk   (CLK),
        .i_rst   (Reset),
        .i_lum   (Lum_sen),
        .i_state (r_state),
        .o_toggle(w_toggle)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= LIGHT_OFF;
        end else if (w_toggle) begin
            r_state <= (r_state == LIGHT_ON) ? LIGHT_OFF : LIGHT_ON;
        end
    end

    assign Ext_light = (r_state == LIGHT_ON);

endmodule

// File: tb/tb_ext_lights.sv
// Directed bench for ext_lights: three configurations (defaults, 40/60 hysteresis,
// 3-sample filter) share one stimulus stream and are checked against a history model.
module tb_ext_lights;

    logic       CLK;
    logic       Reset;
    logic [7:0] lum;
    logic       w_light [3];

    int total = 0;
    int bad   = 0;

    int cfg_on  [3] = '{50, 40, 50};
    int cfg_off [3] = '{50, 60, 50};
    int cfg_n   [3] = '{1, 1, 3};

    // Model: full sample history since the last state change or reset; the lamp
    // flips once the most recent N samples all argue for the opposite state.
    int unsigned m_hist  [3][1024];
    int          m_n     [3];
    int          m_start [3];
    bit          m_on    [3];
    bit          chk_en = 1'b0;

    ext_lights #(.ON_THRESH(50), .OFF_THRESH(50), .STABLE_CYCLES(1)) dut0 (
        .CLK(CLK), .Reset(Reset), .Lum_sen(lum), .Ext_light(w_light[0]));
    ext_lights #(.ON_THRESH(40), .OFF_THRESH(60), .STABLE_CYCLES(1)) dut1 (
        .CLK(CLK), .Reset(Reset), .Lum_sen(lum), .Ext_light(w_light[1]));
    ext_lights #(.ON_THRESH(50), .OFF_THRESH(50), .STABLE_CYCLES(3)) dut2 (
        .CLK(CLK), .Reset(Reset), .Lum_sen(lum), .Ext_light(w_light[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit favours_flip(int i, int unsigned v, bit on);
        if (on) return (v >= cfg_off[i]);
        return (v < cfg_on[i]);
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_n[i] = 0; m_start[i] = 0; m_on[i] = 1'b0;
        end
    end

    always @(posedge CLK or posedge Reset) begin
        for (int i = 0; i < 3; i++) begin
            if (Reset) begin
                m_on[i]    = 1'b0;
                m_start[i] = m_n[i];
            end else begin
                bit all_q;
                m_hist[i][m_n[i]] = int'(lum);
                m_n[i]++;
                if (m_n[i] - m_start[i] >= cfg_n[i]) begin
                    all_q = 1'b1;
                    for (int j = m_n[i] - cfg_n[i]; j < m_n[i]; j++)
                        if (!favours_flip(i, m_hist[i][j], m_on[i])) all_q = 1'b0;
                    if (all_q) begin
                        m_on[i]    = !m_on[i];
                        m_start[i] = m_n[i];
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) check($sformatf("model_cfg%0d", i), w_light[i], m_on[i]);
        end
    end

    task automatic apply(input logic [7:0] v);
        @(negedge CLK);
        lum = v;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        lum   = 'x;
        #2 Reset = 1'b1;
        #1;
        check("reset_during_0", w_light[0], 1'b0);
        check("reset_during_1", w_light[1], 1'b0);
        check("reset_during_2", w_light[2], 1'b0);
        #3 Reset = 1'b0;
        lum    = 8'd90;
        chk_en = 1'b1;
        #1 check("reset_after", w_light[0], 1'b0);

        apply(8'd90);  check("bright_90",  w_light[0], 1'b0);
        apply(8'd20);  check("dark_20",    w_light[0], 1'b1);
        apply(8'd90);  check("bright_back", w_light[0], 1'b0);
        apply(8'd50);  check("bound_50_off", w_light[0], 1'b0);
        apply(8'd49);  check("bound_49_on",  w_light[0], 1'b1);
        apply(8'd50);  check("bound_50_back", w_light[0], 1'b0);

        apply(8'd50);  check("hyst_50_stay0", w_light[1], 1'b0);
        apply(8'd30);  check("hyst_30_on",    w_light[1], 1'b1);
        apply(8'd50);  check("hyst_50_stay1", w_light[1], 1'b1);
        apply(8'd60);  check("hyst_60_off",   w_light[1], 1'b0);

        apply(8'd0);   check("extreme_0",   w_light[0], 1'b1);
        apply(8'd255); check("extreme_255", w_light[0], 1'b0);

        apply(8'd20); apply(8'd20); apply(8'd90);
        check("filter_2_then_bright", w_light[2], 1'b0);
        apply(8'd20); apply(8'd20);
        check("filter_2_pending", w_light[2], 1'b0);
        apply(8'd20);
        check("filter_3_on", w_light[2], 1'b1);

        apply(8'd90); apply(8'd90);
        check("filter_off_pending", w_light[2], 1'b1);
        @(negedge CLK);
        #2 Reset = 1'b1;
        #1 check("reset_mid_count", w_light[2], 1'b0);
        #1 Reset = 1'b0;
        apply(8'd20); apply(8'd20);
        check("post_reset_pending", w_light[2], 1'b0);
        apply(8'd20);
        check("post_reset_on", w_light[2], 1'b1);

        apply(8'd90);
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
